// File: rtl/nand_target_emu.sv
// NAND flash target model: oversampled pin decode, page buffer, page array
// and ready/busy timing for closed-loop checks of a NAND controller.
module nand_target_emu #(
  parameter int         PAGE_BYTES = 64,
  parameter int         NUM_PAGES  = 16,
  parameter int         T_R        = 80,
  parameter int         T_PROG     = 200,
  parameter int         T_ERASE    = 400,
  parameter int         T_RST      = 20,
  parameter logic [7:0] MAKER_ID   = 8'hEC,
  parameter logic [7:0] DEVICE_ID  = 8'hDA
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       F_nCE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_nWE,
  input  logic       F_nRE,
  input  logic       F_nWP,
  input  logic [7:0] F_DIO_i,
  output logic [7:0] F_DIO_o,
  output logic       F_DIO_oe,
  output logic       F_nRB,
  output logic [7:0] E_Status
);
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int RW = $clog2(NUM_PAGES);
  localparam logic [13:0] SYNC_RST = {1'b1, 2'b00, 3'b111, 8'h00};

  typedef enum logic [2:0] {IDLE, ADDR, DIN, BUSY, DOUT} state_t;
  typedef enum logic [2:0] {
    OP_READ, OP_PROG, OP_ERASE, OP_ID, OP_RST
  } op_t;

  logic [13:0] s1, s2;
  logic we_p, re_p;
  logic nce_s, cle_s, ale_s, nwe_s, nre_s, nwp_s;
  logic [7:0] dio_s;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      s1   <= SYNC_RST;
      s2   <= SYNC_RST;
      we_p <= 1'b1;
      re_p <= 1'b1;
    end else begin
      s1   <= {F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, F_DIO_i};
      s2   <= s1;
      we_p <= nwe_s;
      re_p <= nre_s;
    end
  end

  assign {nce_s, cle_s, ale_s, nwe_s, nre_s, nwp_s, dio_s} = s2;

  logic we_rise, re_fall, cmd_v, adr_v, din_v;
  assign we_rise = nwe_s & ~we_p & ~nce_s;
  assign re_fall = ~nre_s & re_p & ~nce_s;
  assign cmd_v   = we_rise & cle_s & ~ale_s;
  assign adr_v   = we_rise & ale_s & ~cle_s;
  assign din_v   = we_rise & ~cle_s & ~ale_s;

  state_t state_q, state_n;
  op_t    op_q, op_n;
  logic [2:0]    need_q, need_n, acnt_q, acnt_n;
  logic [15:0]   cnt_q, cnt_n;
  logic [CW:0]   xidx_q, xidx_n;
  logic [CW-1:0] col_q, col_n;
  logic [RW-1:0] row_q, row_n;
  logic [1:0]    idx_q, idx_n;
  logic [7:0]    dout_q, dout_n;
  logic fail_q, fail_n, smode_q, smode_n;
  logic idm_q, idm_n, nrb_q, nrb_n;

  logic [7:0] pbuf [PAGE_BYTES];
  logic [7:0] arr [NUM_PAGES*PAGE_BYTES];
  logic [RW+CW-1:0] arr_a;
  logic          fill_buf, pb_we, arr_we;
  logic [CW-1:0] pb_wa;
  logic [7:0]    pb_wd, arr_wd, id_byte, status;

  assign arr_a  = {row_q, xidx_q[CW-1:0]};
  assign status = {nwp_s, nrb_q, 5'b0, fail_q};

  always_comb begin
    case (idx_q)
      2'd0:    id_byte = MAKER_ID;
      2'd1:    id_byte = DEVICE_ID;
      default: id_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    need_n  = need_q;
    acnt_n  = acnt_q;
    cnt_n   = cnt_q;
    xidx_n  = xidx_q;
    col_n   = col_q;
    row_n   = row_q;
    fail_n  = fail_q;
    smode_n = smode_q;
    idm_n   = idm_q;
    idx_n   = idx_q;
    dout_n  = dout_q;
    nrb_n   = nrb_q;
    fill_buf = 1'b0;
    pb_we    = 1'b0;
    pb_wa    = col_q;
    pb_wd    = dio_s;
    arr_we   = 1'b0;
    arr_wd   = 8'hFF;
    // Page transfer runs in the first PAGE_BYTES busy cycles.
    if (state_q == BUSY) begin
      if (!xidx_q[CW] && op_q != OP_RST) begin
        xidx_n = xidx_q + 1'b1;
        case (op_q)
          OP_READ: begin
            pb_we = 1'b1;
            pb_wa = xidx_q[CW-1:0];
            pb_wd = arr[arr_a];
          end
          OP_PROG: begin
            arr_we = 1'b1;
            arr_wd = pbuf[xidx_q[CW-1:0]];
          end
          OP_ERASE: arr_we = 1'b1;
          default: ;
        endcase
      end
      if (cnt_q == 16'd0) begin
        nrb_n   = 1'b1;
        idm_n   = 1'b0;
        state_n = (op_q == OP_READ) ? DOUT : IDLE;
      end else begin
        cnt_n = cnt_q - 16'd1;
      end
    end
    if (cmd_v) begin
      if (dio_s == 8'hFF) begin
        state_n = BUSY;
        op_n    = OP_RST;
        cnt_n   = 16'(T_RST - 1);
        fail_n  = 1'b0;
        nrb_n   = 1'b0;
      end else if (dio_s == 8'h70) begin
        smode_n = 1'b1;
      end else if (state_q != BUSY) begin
        case (dio_s)
          8'h90: if (state_q == IDLE || state_q == DOUT) begin
            state_n = ADDR;
            op_n    = OP_ID;
            need_n  = 3'd1;
            acnt_n  = 3'd0;
            smode_n = 1'b0;
          end
          8'h00: begin
            smode_n = 1'b0;
            // After a status poll during a read, 00 resumes data out.
            if (!(state_q == DOUT && !idm_q && smode_q)) begin
              state_n = ADDR;
              op_n    = OP_READ;
              need_n  = 3'd5;
              acnt_n  = 3'd0;
            end
          end
          8'h80: begin
            fill_buf = 1'b1;
            smode_n  = 1'b0;
            state_n  = ADDR;
            op_n     = OP_PROG;
            need_n   = 3'd5;
            acnt_n   = 3'd0;
          end
          8'h60: begin
            smode_n = 1'b0;
            state_n = ADDR;
            op_n    = OP_ERASE;
            need_n  = 3'd3;
            acnt_n  = 3'd0;
          end
          8'h30: begin
            state_n = IDLE;
            if (state_q == ADDR && op_q == OP_READ
                && acnt_q == 3'd5) begin
              state_n = BUSY;
              cnt_n   = 16'(T_R - 1);
              xidx_n  = '0;
              nrb_n   = 1'b0;
            end
          end
          8'h10: begin
            state_n = IDLE;
            if (state_q == DIN) begin
              fail_n = ~nwp_s;
              if (nwp_s) begin
                state_n = BUSY;
                cnt_n   = 16'(T_PROG - 1);
                xidx_n  = '0;
                nrb_n   = 1'b0;
              end
            end
          end
          8'hD0: begin
            state_n = IDLE;
            if (state_q == ADDR && op_q == OP_ERASE
                && acnt_q == 3'd3) begin
              fail_n = ~nwp_s;
              if (nwp_s) begin
                state_n = BUSY;
                cnt_n   = 16'(T_ERASE - 1);
                xidx_n  = '0;
                nrb_n   = 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end else if (adr_v) begin
      if (state_q == ADDR && acnt_q < need_q) begin
        acnt_n = acnt_q + 3'd1;
        if (op_q == OP_ERASE ? acnt_q == 3'd0 : acnt_q == 3'd2)
          row_n = dio_s[RW-1:0];
        if ((op_q == OP_READ || op_q == OP_PROG) && acnt_q == 3'd0)
          col_n = dio_s[CW-1:0];
        if (op_q == OP_PROG && acnt_q == 3'd4)
          state_n = DIN;
        if (op_q == OP_ID) begin
          state_n = DOUT;
          idm_n   = 1'b1;
          idx_n   = 2'd0;
        end
      end
    end else if (din_v) begin
      if (state_q == DIN) begin
        pb_we = 1'b1;
        col_n = col_q + 1'b1;
      end
    end else if (re_fall) begin
      if (state_q == DOUT && !smode_q) begin
        if (idm_q) begin
          dout_n = id_byte;
          idx_n  = idx_q + 2'd1;
        end else begin
          dout_n = pbuf[col_q];
          col_n  = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      need_q  <= 3'd0;
      acnt_q  <= 3'd0;
      cnt_q   <= 16'd0;
      xidx_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fail_q  <= 1'b0;
      smode_q <= 1'b0;
      idm_q   <= 1'b0;
      idx_q   <= 2'd0;
      dout_q  <= 8'h00;
      nrb_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      need_q  <= need_n;
      acnt_q  <= acnt_n;
      cnt_q   <= cnt_n;
      xidx_q  <= xidx_n;
      col_q   <= col_n;
      row_q   <= row_n;
      fail_q  <= fail_n;
      smode_q <= smode_n;
      idm_q   <= idm_n;
      idx_q   <= idx_n;
      dout_q  <= dout_n;
      nrb_q   <= nrb_n;
    end
  end

  // Storage is never cleared; reset only blocks in-flight writes.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      if (fill_buf) begin
        for (int i = 0; i < PAGE_BYTES; i++) pbuf[i] <= 8'hFF;
      end else if (pb_we) begin
        pbuf[pb_wa] <= pb_wd;
      end
      if (arr_we) arr[arr_a] <= arr_wd;
    end
  end

  assign F_nRB    = nrb_q;
  assign E_Status = status;
  assign F_DIO_o  = smode_q ? status : dout_q;
  assign F_DIO_oe = ~nce_s & ~re_p & (smode_q | (state_q == DOUT));

endmodule

// File: tb/tb_nand_target_emu.sv
// Randomized closed-loop bench for nand_target_emu against a page-array
// reference model driven with pin-level NAND cycles.
module tb_nand_target_emu;
  localparam int PB  = 64;
  localparam int NP  = 16;
  localparam int TR  = 80;
  localparam int TP  = 200;
  localparam int TE  = 400;
  localparam int TRS = 20;

  logic       PCLK    = 1'b0;
  logic       PRESET  = 1'b1;
  logic       F_nCE   = 1'b1;
  logic       F_CLE   = 1'b0;
  logic       F_ALE   = 1'b0;
  logic       F_nWE   = 1'b1;
  logic       F_nRE   = 1'b1;
  logic       F_nWP   = 1'b1;
  logic [7:0] F_DIO_i = 8'h00;
  logic [7:0] F_DIO_o, E_Status;
  logic       F_DIO_oe, F_nRB;

  logic [7:0] mem [NP][PB];
  logic [7:0] wq [$];
  logic [7:0] ids [4] = '{8'hEC, 8'hDA, 8'h00, 8'h00};
  bit fail_m;
  int n_chk  = 0;
  int n_fail = 0;

  nand_target_emu #(
    .PAGE_BYTES(PB), .NUM_PAGES(NP), .T_R(TR), .T_PROG(TP),
    .T_ERASE(TE), .T_RST(TRS), .MAKER_ID(8'hEC), .DEVICE_ID(8'hDA)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .F_nCE(F_nCE), .F_CLE(F_CLE),
    .F_ALE(F_ALE), .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP),
    .F_DIO_i(F_DIO_i), .F_DIO_o(F_DIO_o), .F_DIO_oe(F_DIO_oe),
    .F_nRB(F_nRB), .E_Status(E_Status)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic wcyc(logic c, logic a, logic [7:0] d);
    F_CLE = c; F_ALE = a; F_DIO_i = d;
    F_nWE = 1'b0; tick(4);
    F_nWE = 1'b1; tick(4);
    F_CLE = 1'b0; F_ALE = 1'b0;
  endtask

  task automatic cmd(logic [7:0] d); wcyc(1'b1, 1'b0, d); endtask
  task automatic adr(logic [7:0] d); wcyc(1'b0, 1'b1, d); endtask
  task automatic dat(logic [7:0] d); wcyc(1'b0, 1'b0, d); endtask

  task automatic addr5(int col, int pg);
    adr(8'(col)); adr(8'h00); adr(8'(pg)); adr(8'h00); adr(8'h00);
  endtask

  task automatic rd(output logic [7:0] d, output logic oe);
    F_nRE = 1'b0; tick(5);
    d = F_DIO_o; oe = F_DIO_oe;
    F_nRE = 1'b1; tick(5);
  endtask

  // Issues a command and counts the PCLK cycles F_nRB spends low.
  task automatic confirm(logic [7:0] c, int lim, output int low);
    F_CLE = 1'b1; F_DIO_i = c;
    F_nWE = 1'b0; tick(4);
    F_nWE = 1'b1;
    low = 0;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (!F_nRB) low++;
      else if (low > 0) break;
    end
    F_CLE = 1'b0;
  endtask

  function automatic logic [7:0] st_exp(bit wp);
    return {wp, 1'b1, 5'b0, fail_m};
  endfunction

  task automatic chk_status(string tag, bit wp);
    logic [7:0] s; logic oe;
    cmd(8'h70); rd(s, oe);
    check(tag, s, st_exp(wp));
    check({tag, "_oe"}, oe, 1'b1);
  endtask

  task automatic do_prog(int pg, int col, bit wp);
    logic [7:0] b [PB];
    int c, low;
    F_nWP = wp; tick(3);
    cmd(8'h80); addr5(col, pg);
    for (int i = 0; i < PB; i++) b[i] = 8'hFF;
    c = col;
    foreach (wq[i]) begin
      dat(wq[i]); b[c] = wq[i]; c = (c + 1) % PB;
    end
    confirm(8'h10, wp ? TP + 40 : 30, low);
    check("prog_busy", low, wp ? TP : 0);
    if (wp) begin
      for (int i = 0; i < PB; i++) mem[pg][i] = b[i];
      fail_m = 1'b0;
    end else begin
      fail_m = 1'b1;
    end
    chk_status("prog_status", wp);
    F_nWP = 1'b1; tick(3);
  endtask

  task automatic do_erase(int pg, bit wp);
    int low;
    F_nWP = wp; tick(3);
    cmd(8'h60); adr(8'(pg)); adr(8'h00); adr(8'h00);
    confirm(8'hD0, wp ? TE + 40 : 30, low);
    check("erase_busy", low, wp ? TE : 0);
    if (wp) begin
      for (int i = 0; i < PB; i++) mem[pg][i] = 8'hFF;
      fail_m = 1'b0;
    end else begin
      fail_m = 1'b1;
    end
    chk_status("erase_status", wp);
    F_nWP = 1'b1; tick(3);
  endtask

  task automatic do_read(int pg, int col, int n);
    logic [7:0] d; logic oe; int low;
    cmd(8'h00); addr5(col, pg);
    confirm(8'h30, TR + 40, low);
    check("read_busy", low, TR);
    for (int i = 0; i < n; i++) begin
      rd(d, oe);
      check("read_data", d, mem[pg][(col + i) % PB]);
      check("read_oe", oe, 1'b1);
    end
  endtask

  task automatic do_id();
    logic [7:0] d; logic oe;
    cmd(8'h90); adr(8'h00);
    for (int i = 0; i < 5; i++) begin
      rd(d, oe);
      check("id_byte", d, ids[i % 4]);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, pg, op, n;
    tick(4);
    check("rst_nrb", F_nRB, 1'b1);
    check("rst_oe", F_DIO_oe, 1'b0);
    check("rst_dio", F_DIO_o, 8'h00);
    PRESET = 1'b0;
    tick(3);
    check("rst_status", E_Status, 8'hC0);
    F_nCE = 1'b0; tick(3);

    for (int p = 0; p < 4; p++) do_erase(p, 1'b1);

    wq = '{8'hA5, 8'h5A};
    do_prog(3, 0, 1'b1);
    do_read(3, 0, 3);
    do_read(3, 63, 2);
    do_erase(3, 1'b1);
    do_read(3, 0, 4);
    wq = '{8'h11, 8'h22};
    do_prog(3, 0, 1'b0);
    do_read(3, 0, 2);
    do_id();

    // Reset command while a program is busy.
    cmd(8'h80); addr5(0, 5); dat(8'h77);
    cmd(8'h10); tick(20);
    check("prog_busy_mid", F_nRB, 1'b0);
    confirm(8'hFF, 100, low);
    check("rst_cmd_busy", low, TRS + 2);
    fail_m = 1'b0;
    chk_status("rst_cmd_status", 1'b1);

    // PRESET in the middle of data-in must leave the page untouched.
    wq = '{8'h12, 8'h34};
    do_prog(2, 0, 1'b1);
    cmd(8'h80); addr5(0, 2); dat(8'h33); dat(8'h44);
    PRESET = 1'b1; tick(1);
    check("preset_nrb", F_nRB, 1'b1);
    check("preset_oe", F_DIO_oe, 1'b0);
    PRESET = 1'b0; fail_m = 1'b0; tick(3);
    check("preset_status", E_Status, 8'hC0);
    do_read(2, 0, 3);

    for (int it = 0; it < 20; it++) begin
      pg = $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          wq.delete();
          n = $urandom_range(1, 4);
          repeat (n) wq.push_back(8'($urandom));
          do_prog(pg, $urandom_range(0, 63), $urandom_range(0, 3) != 0);
        end
        1: do_erase(pg, $urandom_range(0, 3) != 0);
        2: begin
          n = ($urandom_range(0, 1) != 0) ? $urandom_range(60, 63)
                                          : $urandom_range(0, 63);
          do_read(pg, n, $urandom_range(1, 3));
        end
        default: do_id();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
